// File: rtl/hps_pio_word_feeder_pkg.sv
// Shared widths and FSM state type for the HPS parallel-input word feeder.
package hps_pio_pkg;

    localparam int PIO_W     = 32;
    localparam int PAYLOAD_W = 31;
    localparam int SEQ_BIT   = 31;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } feeder_state_t;

endpackage

// File: rtl/hps_pio_word_feeder_if.sv
// Producer stream and HPS PIO pair seen by the word feeder.
interface hps_pio_word_feeder_if;
    import hps_pio_pkg::*;

    logic [PAYLOAD_W-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 hps_ack;
    logic [PIO_W-1:0]     parallel_input;

    modport master (
        output in_data,
        output in_valid,
        output hps_ack,
        input  in_ready,
        input  parallel_input
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  hps_ack,
        output in_ready,
        output parallel_input
    );

endinterface

// File: rtl/hps_pio_word_feeder_fifo.sv
// Single-clock FIFO with a registered read port (rd_data updates on the pop edge).
module hps_pio_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 31
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (wr_ptr == rd_ptr);
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // Pointer advance and registered read of the head word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_ok) begin
                rd_ptr  <= rd_ptr + (AW+1)'(1);
                rd_data <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    // Storage array write.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/hps_pio_word_feeder.sv
// Buffers producer words and presents them one at a time on the HPS PIO bus,
// advancing on each toggle of the HPS acknowledge PIO.
module hps_pio_word_feeder
    import hps_pio_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    hps_pio_word_feeder_if.slave        pio,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        pending,
    output logic [31:0]                 words_sent
);

    feeder_state_t        state;
    logic                 seq;
    logic                 ack_ref;
    logic                 ack_s;
    logic                 ack_hit;
    logic                 ready_en;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_rd;
    logic [PAYLOAD_W-1:0] head;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign ack_s = pio.hps_ack;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            // Synchronizer chain for the HPS acknowledge PIO.
            always_ff @(posedge clk_clk) begin
                if (!reset_reset_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= pio.hps_ack;
                    for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign ack_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Holds in_ready low throughout reset, releases it the cycle after.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) ready_en <= 1'b0;
        else                ready_en <= 1'b1;
    end

    assign pio.in_ready = ready_en && !fifo_full;
    assign ack_hit      = (ack_s != ack_ref);

    hps_pio_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PAYLOAD_W)
    ) u_fifo (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .wr_en   (pio.in_valid && pio.in_ready),
        .wr_data (pio.in_data),
        .rd_en   (fifo_rd),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Pop decision: load a word from IDLE, or back-to-back after an acknowledge.
    always_comb begin
        fifo_rd = 1'b0;
        if (!fifo_empty) begin
            if (state == ST_IDLE)     fifo_rd = 1'b1;
            else if (ack_hit)         fifo_rd = 1'b1;
        end
    end

    // Presentation FSM; seq flips on the same edge the FIFO read register loads the payload.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state      <= ST_IDLE;
            seq        <= 1'b0;
            ack_ref    <= 1'b0;
            words_sent <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ack_ref <= ack_s;
                    if (!fifo_empty) begin
                        seq   <= ~seq;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (ack_hit) begin
                        ack_ref    <= ack_s;
                        words_sent <= words_sent + 32'd1;
                        if (!fifo_empty) seq   <= ~seq;
                        else             state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign pio.parallel_input = {seq, head};
    assign pending            = (state == ST_WAIT);

endmodule

// File: tb/tb_hps_pio_word_feeder.sv
// Scoreboard bench for hps_pio_word_feeder: stimulus queues expected bus words,
// a monitor pops and compares each time the bus presents a new word.
module tb_hps_pio_word_feeder;
    import hps_pio_pkg::*;

    localparam int DEPTH = 8;
    localparam int SYNC  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  fifo_level;
    logic        pending;
    logic [31:0] words_sent;

    hps_pio_word_feeder_if bus_if();

    hps_pio_word_feeder #(
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .pio           (bus_if),
        .fifo_level    (fifo_level),
        .pending       (pending),
        .words_sent    (words_sent)
    );

    always #5 clk = ~clk;

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] sb [$];
    logic        exp_seq;
    logic [31:0] prev_bus;
    logic [31:0] exp_w;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every new bus word must match the scoreboard head.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            prev_bus = '0;
        end else if (bus_if.parallel_input !== prev_bus) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_word: got 0x%08h expected no change from 0x%08h",
                         bus_if.parallel_input, prev_bus);
            end else begin
                exp_w = sb.pop_front();
                check("bus_word", bus_if.parallel_input, exp_w);
            end
            prev_bus = bus_if.parallel_input;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge with in_valid still high.
    task automatic push(input logic [30:0] d);
        int n = 0;
        exp_seq = ~exp_seq;
        sb.push_back({exp_seq, d});
        bus_if.in_data  = d;
        bus_if.in_valid = 1'b1;
        while (!bus_if.in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!bus_if.in_ready) begin
            compared++;
            mismatched++;
            $display("FAIL push_timeout: in_ready got 0 required 1");
        end
        @(negedge clk);
    endtask

    task automatic ack_word();
        bus_if.hps_ack = bus_if.parallel_input[SEQ_BIT];
        repeat (SYNC + 1) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n           = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = '0;
        bus_if.hps_ack  = 1'b0;
        exp_seq         = 1'b0;
        prev_bus        = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_bus",      bus_if.parallel_input, 32'h0);
        check("rst_in_ready", {31'b0, bus_if.in_ready}, 32'h0);
        check("rst_pending",  {31'b0, pending}, 32'h0);
        check("rst_sent",     words_sent, 32'h0);
        check("rst_level",    {28'b0, fifo_level}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'b0, bus_if.in_ready}, 32'h1);

        // First word: two-cycle latency, seq = 1
        push(31'h123);
        bus_if.in_valid = 1'b0;
        check("lat1_bus", bus_if.parallel_input, 32'h0);
        @(negedge clk);
        check("lat2_bus",     bus_if.parallel_input, 32'h8000_0123);
        check("lat2_pending", {31'b0, pending}, 32'h1);
        check("lat2_sent",    words_sent, 32'h0);

        // Ack latency SYNC+1 with the next word already queued
        push(31'h456);
        bus_if.in_valid = 1'b0;
        check("q1_level", {28'b0, fifo_level}, 32'h1);
        bus_if.hps_ack = 1'b1;
        repeat (SYNC) @(negedge clk);
        check("ack_hold_bus", bus_if.parallel_input, 32'h8000_0123);
        @(negedge clk);
        check("ack_next_bus", bus_if.parallel_input, 32'h0000_0456);
        check("ack_next_sent", words_sent, 32'h1);

        // Fill to full, hold an extra word at the producer, then drain in order
        ack_word();
        check("idle_pending", {31'b0, pending}, 32'h0);
        check("idle_sent",    words_sent, 32'h2);
        for (int i = 0; i <= DEPTH; i++) begin
            push(31'(32'h100 + i));
            if (i == DEPTH - 1) check("fill_level_m1", {28'b0, fifo_level}, DEPTH - 1);
        end
        check("full_level", {28'b0, fifo_level}, DEPTH);
        check("full_ready", {31'b0, bus_if.in_ready}, 32'h0);
        exp_seq = ~exp_seq;
        sb.push_back({exp_seq, 31'h1ff});
        bus_if.in_data = 31'h1ff;
        repeat (3) begin
            @(negedge clk);
            check("held_ready", {31'b0, bus_if.in_ready}, 32'h0);
        end
        check("held_level", {28'b0, fifo_level}, DEPTH);
        bus_if.hps_ack = bus_if.parallel_input[SEQ_BIT];
        n = 0;
        while (!bus_if.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("held_accept_ready", {31'b0, bus_if.in_ready}, 32'h1);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        check("held_accept_level", {28'b0, fifo_level}, DEPTH);
        n = 0;
        while (pending && n < 100) begin
            ack_word();
            n++;
        end
        check("drain_sent",  words_sent, 32'(2 + DEPTH + 2));
        check("drain_level", {28'b0, fifo_level}, 32'h0);
        check("drain_sb",    32'(sb.size()), 32'h0);

        // Spurious ack in IDLE: absorbed, no count; 12 words sent so far, so next seq = 1
        bus_if.hps_ack = ~bus_if.hps_ack;
        repeat (6) @(negedge clk);
        check("spur_sent",    words_sent, 32'(2 + DEPTH + 2));
        check("spur_pending", {31'b0, pending}, 32'h0);
        push(31'h777);
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        check("spur_next_bus", bus_if.parallel_input, 32'h8000_0777);

        // Reset while pending with five words queued
        for (int i = 0; i < 5; i++) push(31'(32'h200 + i));
        bus_if.in_valid = 1'b0;
        check("pre_rst_level", {28'b0, fifo_level}, 32'h5);
        rst_n = 1'b0;
        sb.delete();
        exp_seq        = 1'b0;
        bus_if.hps_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_bus",     bus_if.parallel_input, 32'h0);
        check("mid_rst_level",   {28'b0, fifo_level}, 32'h0);
        check("mid_rst_pending", {31'b0, pending}, 32'h0);
        check("mid_rst_sent",    words_sent, 32'h0);
        @(negedge clk);
        check("mid_rst_ready",   {31'b0, bus_if.in_ready}, 32'h1);

        // Continuous stream of 1000 words, HPS model acks every 3 cycles
        fork
            begin
                for (int i = 0; i < 1000; i++) push(31'(i * 7 + 32'h1000));
                bus_if.in_valid = 1'b0;
            end
            begin
                int cyc = 0;
                while (words_sent != 32'd1000 && cyc < 20000) begin
                    repeat (3) @(negedge clk);
                    cyc += 3;
                    if (pending && bus_if.parallel_input[SEQ_BIT] !== bus_if.hps_ack)
                        bus_if.hps_ack = bus_if.parallel_input[SEQ_BIT];
                end
            end
        join
        check("stream_sent", words_sent, 32'd1000);
        check("stream_sb",   32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hps_pio_word_feeder.md
Name: hps_pio_word_feeder

Overview:
- Upstream stage of the HPS parallel-input bridge.
- Accepts 31-bit payload words from fabric producers over a valid/ready stream and buffers them in a FIFO.
- Presents one word at a time on the 32-bit PIO input bus (parallel_input_export), with bit 31 as a sequence toggle.
- Advances to the next word only after the HPS acknowledges by toggling its single-bit PIO output (hps_valid_export).

Parameters:
- FIFO_DEPTH, 16, payload words buffered; power of two, 2..256.
- SYNC_STAGES, 2, flops on hps_valid_export before use; 0 means used directly as a registered input.

Ports:
- clk_clk  input  1  system clock, same clock as the HPS system PIOs
- reset_reset_n  input  1  synchronous active-low reset
- in_data  input  31  producer payload
- in_valid  input  1  producer word valid
- in_ready  output  1  feeder can accept; equals FIFO not full
- hps_ack  input  1  connects to hps_valid_export; HPS toggles it once per word consumed
- parallel_input  output  32  connects to parallel_input_export; [31] = seq toggle, [30:0] = payload
- fifo_level  output  $clog2(FIFO_DEPTH)+1  words in FIFO; excludes the word on the bus
- pending  output  1  a presented word is awaiting acknowledge
- words_sent  output  32  count of acknowledged words; wraps at 2^32

Behaviour:
- Reset values (synchronous, reset_reset_n low at a clk_clk edge):
  - parallel_input = 0, seq bit = 0, pending = 0, words_sent = 0, fifo_level = 0.
  - in_ready = 0 during reset; in_ready = 1 on the first cycle after reset.
  - The synchronizer chain is cleared to 0, and the ack-reference register is set to 0.
- Producer handshake:
  - A word is written when in_valid && in_ready at the clock edge.
  - When full, in_ready = 0 and in_data is ignored; nothing is dropped.
- Synchronized ack: ack_s is hps_ack after SYNC_STAGES flops.
- State machine:
  - IDLE (pending = 0):
    - FIFO empty: stay in IDLE.
    - FIFO non-empty: pop the FIFO head.
    - Next cycle: parallel_input[30:0] = head and parallel_input[31] toggles, then go to WAIT.
    - The seq bit and payload update on the same edge, so the bus never shows a mixed word.
  - WAIT (pending = 1):
    - parallel_input is held stable.
    - When ack_s != ack_ref: set ack_ref = ack_s and increment words_sent.
    - If the FIFO is non-empty in that same cycle, load the next word directly (back-to-back, stay in WAIT).
    - Otherwise go to IDLE.
- Acknowledge rules:
  - The acknowledge condition is ack_s != ack_ref; the HPS writes hps_valid_export = the seq bit it just read.
  - An ack change seen in IDLE (spurious) is absorbed: ack_ref = ack_s, no count.
  - Multiple hps_ack toggles between samples collapse into a parity; an even number of toggles is not an ack. This is documented behaviour.
- Latency:
  - Producer write into empty IDLE feeder to bus update: 2 cycles (FIFO write, then pop/present).
  - hps_ack toggle to next word on bus: SYNC_STAGES + 1 cycles.
- Simultaneous events:
  - Push and pop in the same cycle leave fifo_level unchanged.
  - A full FIFO with a pop in that cycle still reports in_ready = 0 that cycle (no combinational ready from pop).
- Wrap-around: FIFO pointers wrap modulo FIFO_DEPTH; words_sent wraps silently.
- Reset mid-operation: the FIFO contents and presented word are discarded and the seq bit returns to 0. HPS software must resynchronize by reading seq = 0 and writing ack = 0.

Decomposition:
- Package hps_pio_pkg holds:
  - PIO_W = 32, PAYLOAD_W = 31, SEQ_BIT = 31
  - the state enum {ST_IDLE, ST_WAIT}
- One sub-module: hps_pio_sync_fifo, a single-clock synchronous FIFO with DEPTH and WIDTH parameters, full/empty/level outputs, and a registered read port.

Test Plan:
- Reset, then push 0x0000_0123: bus = 0x8000_0123 two cycles after the write; pending = 1, words_sent = 0.
- With 0x8000_0123 pending, push 0x0000_0456 and set hps_ack = 1: bus = 0x0000_0456 (seq 0) exactly SYNC_STAGES + 1 cycles after the toggle; words_sent = 1.
- Push FIFO_DEPTH + 1 words with no acks: one word on the bus, fifo_level = FIFO_DEPTH - 1... then FIFO_DEPTH; in_ready = 0 at full; the extra word is held by the producer, not lost. Ack all words; the payload order matches the push order.
- In IDLE with an empty FIFO, toggle hps_ack: no count and no bus change; the next pushed word uses seq = previous seq inverted.
- Assert reset_reset_n = 0 for 1 cycle while pending with 5 words queued: the next cycle shows bus = 0, fifo_level = 0, pending = 0, words_sent = 0.
- Push a continuous stream while a software model acks every 3 cycles for 1000 words: no loss or duplication, and words_sent = 1000.
